muldiv_seq: RTL

- Multi-cycle sequencer for the multiply (ALU control code 4'b1100) and divide (4'b0011) operations, which the single-cycle ALU cannot complete in one cycle.
- Accepts one op per start pulse and iterates a shift-add multiplier or a restoring divider over DATA_W cycles. Results are written into HI/LO registers.
- Drives stall_o to hold the pipeline while the operation is in flight.
- Sits beside the ALU and is fed by the ALU controller output plus the register-file read data.

---
 rtl/muldiv_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle signed multiply / divide sequencer for the ALU.
//
// One operation is accepted per start pulse. A shift-add multiplier or a
// restoring divider then runs on the operand magnitudes for DATA_W cycles.
// A single fix-up cycle applies the sign correction, and the result is
// registered into HI/LO.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-low reset
//   start_i  in   request pulse, sampled only in IDLE
//   op_i     in   ALU control code (MUL_CODE / DIV_CODE accepted)
//   src_a_i  in   multiplicand / dividend (two's complement)
//   src_b_i  in   multiplier / divisor (two's complement)
//   flush_i  in   abort current operation
//   busy_o   out  state != IDLE
//   stall_o  out  busy_o | (start_i & valid op in IDLE), combinational
//   done_o   out  one-cycle pulse when HI/LO were updated
//   div0_o   out  divide-by-zero flag, cleared on next accepted start
//   hi_o     out  product upper half / remainder
//   lo_o     out  product lower half / quotient
module muldiv_seq #(
    parameter int unsigned DATA_W   = 32,
    parameter logic [3:0]  MUL_CODE = 4'b1100,
    parameter logic [3:0]  DIV_CODE = 4'b0011
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              div0_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_is_div;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [DATA_W-1:0]   r_a_mag;
    logic [DATA_W-1:0]   r_b_mag;
    logic [DATA_W-1:0]   r_src_a;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_div0;

    logic                w_valid_op;
    logic                w_accept;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_trial;
    logic [2*DATA_W-1:0] w_acc_next;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic                w_upd;

    assign w_valid_op = (op_i == MUL_CODE) || (op_i == DIV_CODE);
    assign w_accept   = (r_state == S_IDLE) && start_i && !flush_i && w_valid_op;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(W-1).
    assign w_a_mag = src_a_i[DATA_W-1] ? -src_a_i : src_a_i;
    assign w_b_mag = src_b_i[DATA_W-1] ? -src_b_i : src_b_i;

    // MUL: acc = {partial product, multiplier}; add multiplicand into the
    // upper half when the multiplier LSB is set, then shift right with carry.
    assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                     + (r_acc[0] ? {1'b0, r_a_mag} : '0);

    // DIV: acc = {partial remainder, dividend/quotient}; shift left one bit,
    // trial-subtract divisor, keep the result if non-negative.
    assign w_rem_sh = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_trial  = w_rem_sh - {1'b0, r_b_mag};

    always_comb begin
        w_acc_next = r_acc;
        if (r_is_div) begin
            if (!w_trial[DATA_W]) begin
                w_acc_next = {w_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
            end else begin
                w_acc_next = {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_mul_sum, r_acc[DATA_W-1:1]};
        end
    end

    // Sign correction applied in FIX
    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_sign_a ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    assign w_upd  = (r_state == S_FIX) && !flush_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_CALC;
            S_CALC: begin
                if (flush_i)            w_next = S_IDLE;
                else if (r_cnt == LAST) w_next = S_FIX;
            end
            S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_src_a  <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div0   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_is_div <= (op_i == DIV_CODE);
                r_sign_a <= src_a_i[DATA_W-1];
                r_sign_b <= src_b_i[DATA_W-1];
                r_a_mag  <= w_a_mag;
                r_b_mag  <= w_b_mag;
                r_src_a  <= src_a_i;
                r_div0   <= 1'b0;
                r_cnt    <= '0;
                // Low half seeds the operand that is shifted out bit by bit
                r_acc    <= (op_i == DIV_CODE) ? {{DATA_W{1'b0}}, w_a_mag}
                                               : {{DATA_W{1'b0}}, w_b_mag};
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_upd) begin
                if (!r_is_div) begin
                    r_hi <= w_prod[2*DATA_W-1:DATA_W];
                    r_lo <= w_prod[DATA_W-1:0];
                end else if (r_b_mag == '0) begin
                    r_hi   <= r_src_a;
                    r_lo   <= '1;
                    r_div0 <= 1'b1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign busy_o  = (r_state != S_IDLE);
    assign stall_o = busy_o || ((r_state == S_IDLE) && start_i && w_valid_op);
    assign done_o  = (r_state == S_DONE);
    assign div0_o  = r_div0;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule
